// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared constants, ownership state type and address helper for the ping-pong RAM
package fft_pkg;

  localparam int RD_LAT_1   = 1;
  localparam int RD_LAT_2   = 2;
  localparam int BANK_IDX_W = 1;
  localparam int AWL_MAX    = 16;

  typedef struct packed {
    logic [1:0]            full;
    logic [BANK_IDX_W-1:0] wr_sel;
    logic [BANK_IDX_W-1:0] rd_sel;
  } own_state_t;

  // Reverse the full AWL_MAX-bit word, then drop the unused low bits so only awl bits remain reversed.
  function automatic logic [AWL_MAX-1:0] bit_reverse(input logic [AWL_MAX-1:0] addr, input int awl);
    logic [AWL_MAX-1:0] rev;
    for (int i = 0; i < AWL_MAX; i++) begin
      rev[i] = addr[AWL_MAX-1-i];
    end
    return rev >> (AWL_MAX - awl);
  endfunction

endpackage

// File: rtl/fft_pingpong_ram_if.sv
// rtl/fft_pingpong_ram_if.sv - writer/reader bus of the ping-pong sample RAM
interface fft_pingpong_ram_if
  import fft_pkg::*;
#(
  parameter int DWL = 32,
  parameter int AWL = 8
);
  logic                  i_WR_EN;
  logic [AWL-1:0]        i_WR_ADDR;
  logic [DWL-1:0]        i_WR_DATA;
  logic                  i_WR_DONE;
  logic                  o_WR_READY;
  logic [BANK_IDX_W-1:0] o_WR_BANK;
  logic                  i_RD_EN;
  logic [AWL-1:0]        i_RD_ADDR;
  logic                  i_RD_DONE;
  logic [DWL-1:0]        o_RD_DATA;
  logic                  o_RD_VALID;
  logic                  o_RD_READY;
  logic [BANK_IDX_W-1:0] o_RD_BANK;
  logic [1:0]            o_FULL_CNT;

  modport master (
    output i_WR_EN, i_WR_ADDR, i_WR_DATA, i_WR_DONE, i_RD_EN, i_RD_ADDR, i_RD_DONE,
    input  o_WR_READY, o_WR_BANK, o_RD_DATA, o_RD_VALID, o_RD_READY, o_RD_BANK, o_FULL_CNT
  );

  modport slave (
    input  i_WR_EN, i_WR_ADDR, i_WR_DATA, i_WR_DONE, i_RD_EN, i_RD_ADDR, i_RD_DONE,
    output o_WR_READY, o_WR_BANK, o_RD_DATA, o_RD_VALID, o_RD_READY, o_RD_BANK, o_FULL_CNT
  );

endinterface

// File: rtl/fft_bank_ram.sv
// rtl/fft_bank_ram.sv - one sample bank: single write port, registered synchronous read port
module fft_bank_ram #(
  parameter int DWL = 32,
  parameter int AWL = 8
) (
  input  logic           i_clk,
  input  logic           i_wr_en,
  input  logic [AWL-1:0] i_wr_addr,
  input  logic [DWL-1:0] i_wr_data,
  input  logic           i_rd_en,
  input  logic [AWL-1:0] i_rd_addr,
  output logic [DWL-1:0] o_rd_data
);
  logic [DWL-1:0] r_mem [2**AWL];
  logic [DWL-1:0] r_rd_data;

  // Read data only updates on an enabled read, so it holds between reads.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
    if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/fft_pingpong_ram.sv
// rtl/fft_pingpong_ram.sv - double-buffered FFT sample memory with done-pulse bank handover
module fft_pingpong_ram
  import fft_pkg::*;
#(
  parameter int DWL     = 32,
  parameter int AWL     = 8,
  parameter int BIT_REV = 0,
  parameter int RD_LAT  = 1
) (
  input logic               CLK,
  input logic               RST_N,
  fft_pingpong_ram_if.slave bus
);
  own_state_t            r_own;
  own_state_t            w_own_nxt;
  logic                  w_wr_ready;
  logic                  w_rd_ready;
  logic                  w_wr_acc;
  logic                  w_rd_acc;
  logic [AWL-1:0]        w_wr_addr;
  logic [DWL-1:0]        w_bank_q [2];
  logic [DWL-1:0]        w_sel_q;
  logic                  r_vld1;
  logic                  r_vld2;
  logic                  r_data_ok;
  logic [BANK_IDX_W-1:0] r_last_bank;
  logic [DWL-1:0]        r_rd_data;

  if (RD_LAT != RD_LAT_1 && RD_LAT != RD_LAT_2) begin : g_bad_rd_lat
    $error("fft_pingpong_ram: RD_LAT must be 1 or 2");
  end
  if (AWL > AWL_MAX || AWL < 1) begin : g_bad_awl
    $error("fft_pingpong_ram: AWL out of range");
  end

  assign w_wr_ready = ~r_own.full[r_own.wr_sel];
  assign w_rd_ready = r_own.full[r_own.rd_sel];
  assign w_wr_acc   = bus.i_WR_EN & w_wr_ready & RST_N;
  assign w_rd_acc   = bus.i_RD_EN & w_rd_ready & RST_N;

  if (BIT_REV != 0) begin : g_wr_rev
    assign w_wr_addr = AWL'(bit_reverse(AWL_MAX'(bus.i_WR_ADDR), AWL));
  end else begin : g_wr_nat
    assign w_wr_addr = bus.i_WR_ADDR;
  end

  // When both sides are ready they own different banks, so both updates apply independently.
  always_comb begin
    w_own_nxt = r_own;
    if (bus.i_WR_DONE && w_wr_ready) begin
      w_own_nxt.full[r_own.wr_sel] = 1'b1;
      w_own_nxt.wr_sel             = ~r_own.wr_sel;
    end
    if (bus.i_RD_DONE && w_rd_ready) begin
      w_own_nxt.full[r_own.rd_sel] = 1'b0;
      w_own_nxt.rd_sel             = ~r_own.rd_sel;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_own <= '0;
    end else begin
      r_own <= w_own_nxt;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    localparam logic [BANK_IDX_W-1:0] BANK_ID = BANK_IDX_W'(b);
    fft_bank_ram #(.DWL(DWL), .AWL(AWL)) u_ram (
      .i_clk     (CLK),
      .i_wr_en   (w_wr_acc && (r_own.wr_sel == BANK_ID)),
      .i_wr_addr (w_wr_addr),
      .i_wr_data (bus.i_WR_DATA),
      .i_rd_en   (w_rd_acc && (r_own.rd_sel == BANK_ID)),
      .i_rd_addr (bus.i_RD_ADDR),
      .o_rd_data (w_bank_q[b])
    );
  end

  // Bank RAMs carry no reset, so read data is forced to zero until the first read after reset.
  assign w_sel_q = r_data_ok ? w_bank_q[r_last_bank] : '0;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_vld1      <= 1'b0;
      r_vld2      <= 1'b0;
      r_data_ok   <= 1'b0;
      r_last_bank <= '0;
      r_rd_data   <= '0;
    end else begin
      r_vld1 <= w_rd_acc;
      r_vld2 <= r_vld1;
      if (w_rd_acc) begin
        r_data_ok   <= 1'b1;
        r_last_bank <= r_own.rd_sel;
      end
      if (r_vld1) r_rd_data <= w_sel_q;
    end
  end

  assign bus.o_RD_DATA  = (RD_LAT == RD_LAT_1) ? w_sel_q : r_rd_data;
  assign bus.o_RD_VALID = (RD_LAT == RD_LAT_1) ? r_vld1 : r_vld2;
  assign bus.o_WR_READY = w_wr_ready;
  assign bus.o_RD_READY = w_rd_ready;
  assign bus.o_WR_BANK  = r_own.wr_sel;
  assign bus.o_RD_BANK  = r_own.rd_sel;
  assign bus.o_FULL_CNT = {1'b0, r_own.full[0]} + {1'b0, r_own.full[1]};

endmodule
